// File: rtl/alu_seq_pkg.sv
// Shared constants, opcode encodings, FSM state type and request payload for alu_seq_arb.
// Define ALU_SEQ_RR_EN to select round-robin arbitration; the default is fixed priority.
package alu_seq_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned ID_W    = 1;

    localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
    localparam logic [OP_W-1:0] OP_AND  = 4'b0010;
    localparam logic [OP_W-1:0] OP_OR   = 4'b0011;
    localparam logic [OP_W-1:0] OP_NOT  = 4'b0100;
    localparam logic [OP_W-1:0] OP_SRA  = 4'b1000;
    localparam logic [OP_W-1:0] OP_SLL  = 4'b1001;
    localparam logic [OP_W-1:0] OP_SRL  = 4'b1010;
    localparam logic [OP_W-1:0] OP_ROTL = 4'b1100;
    localparam logic [OP_W-1:0] OP_ROTR = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } req_t;

    // Only the defined shift/rotate encodings iterate; undefined ops take the single-cycle path.
    function automatic logic is_shift(input logic [OP_W-1:0] op);
        case (op)
            OP_SRA, OP_SLL, OP_SRL, OP_ROTL, OP_ROTR: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; shift and rotate opcodes move the operand by exactly one bit.
module alu
    import alu_seq_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] out_c
);

    always_comb begin
        out_c = '0;
        case (op)
            OP_ADD:  out_c = a + b;
            OP_SUB:  out_c = a - b;
            OP_AND:  out_c = a & b;
            OP_OR:   out_c = a | b;
            OP_NOT:  out_c = ~a;
            OP_SRA:  out_c = {a[DATA_W-1], a[DATA_W-1:1]};
            OP_SLL:  out_c = {a[DATA_W-2:0], 1'b0};
            OP_SRL:  out_c = {1'b0, a[DATA_W-1:1]};
            OP_ROTL: out_c = {a[DATA_W-2:0], a[DATA_W-1]};
            OP_ROTR: out_c = {a[0], a[DATA_W-1:1]};
            default: out_c = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_arb.sv
// Two-requester front end for a single ALU; multi-bit shifts are iterated one bit per cycle.
// ALU_SEQ_RR_EN selects round-robin arbitration, otherwise requester 0 has fixed priority.
module alu_seq_arb
    import alu_seq_pkg::*;
(
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        Req_Valid,
    output logic [NUM_REQ-1:0]        Req_Ready,
    input  logic [NUM_REQ*DATA_W-1:0] Req_A,
    input  logic [NUM_REQ*DATA_W-1:0] Req_B,
    input  logic [NUM_REQ*OP_W-1:0]   Req_Op,
    output logic                      Rsp_Valid,
    input  logic                      Rsp_Ready,
    output logic [ID_W-1:0]           Rsp_Id,
    output logic [DATA_W-1:0]         Rsp_Out,
    output logic                      Rsp_Zero,
    output logic                      Busy
);

    state_t            state_q;
    state_t            state_d;
    logic [ID_W-1:0]   grant_idx_c;
    logic [NUM_REQ-1:0] req_ready_c;
    logic              xfer_c;
    req_t              sel_c;

    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] b_q;
    logic [OP_W-1:0]   op_q;
    logic [ID_W-1:0]   id_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              shift_c;
    logic              exec_last_c;
    logic [DATA_W-1:0] alu_b_c;
    logic [DATA_W-1:0] alu_out_c;
    logic [DATA_W-1:0] result_c;

`ifdef ALU_SEQ_RR_EN
    logic [ID_W-1:0]   last_q;
`endif

    // Grant selection: a lone requester always wins; contention follows the configured policy.
    always_comb begin
        grant_idx_c = '0;
        if (&Req_Valid) begin
`ifdef ALU_SEQ_RR_EN
            grant_idx_c = ~last_q;
`else
            grant_idx_c = '0;
`endif
        end else if (Req_Valid[1]) begin
            grant_idx_c = ID_W'(1);
        end
    end

    // Ready is offered only in IDLE and held low while Reset is asserted.
    always_comb begin
        req_ready_c = '0;
        if ((state_q == ST_IDLE) && !Reset && (|Req_Valid)) begin
            req_ready_c = NUM_REQ'(1) << grant_idx_c;
        end
    end

    assign Req_Ready = req_ready_c;
    assign xfer_c    = |(Req_Valid & req_ready_c);

    always_comb begin
        sel_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx_c == ID_W'(i)) begin
                sel_c.op = Req_Op[i*OP_W +: OP_W];
                sel_c.a  = Req_A[i*DATA_W +: DATA_W];
                sel_c.b  = Req_B[i*DATA_W +: DATA_W];
            end
        end
    end

    // Non-shift ops load a zero count, so a count of 0 or 1 marks the final EXEC cycle for every op.
    assign shift_c     = is_shift(op_q);
    assign exec_last_c = (cnt_q <= CNT_W'(1));
    assign alu_b_c     = shift_c ? DATA_W'(1) : b_q;
    assign result_c    = (shift_c && (cnt_q == '0)) ? acc_q : alu_out_c;

    alu u_alu (
        .a     (acc_q),
        .b     (alu_b_c),
        .op    (op_q),
        .out_c (alu_out_c)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (xfer_c)                  state_d = ST_EXEC;
            ST_EXEC: if (exec_last_c)             state_d = ST_RESP;
            ST_RESP: if (Rsp_Valid && Rsp_Ready)  state_d = ST_IDLE;
            default:                              state_d = ST_IDLE;
        endcase
    end

    // Operand capture and iterative shift accumulator.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            acc_q <= '0;
            b_q   <= '0;
            op_q  <= '0;
            id_q  <= '0;
            cnt_q <= '0;
        end else if (xfer_c) begin
            acc_q <= sel_c.a;
            b_q   <= sel_c.b;
            op_q  <= sel_c.op;
            id_q  <= grant_idx_c;
            cnt_q <= is_shift(sel_c.op) ? sel_c.b[CNT_W-1:0] : '0;
        end else if ((state_q == ST_EXEC) && shift_c && (cnt_q != '0)) begin
            acc_q <= alu_out_c;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

`ifdef ALU_SEQ_RR_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            last_q <= ID_W'(1);
        end else if (xfer_c) begin
            last_q <= grant_idx_c;
        end
    end
`endif

    // Response registers are loaded once on leaving EXEC and then held until the handshake.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Rsp_Valid <= 1'b0;
            Rsp_Out   <= '0;
            Rsp_Zero  <= 1'b1;
            Rsp_Id    <= '0;
            Busy      <= 1'b0;
        end else begin
            Rsp_Valid <= (state_d == ST_RESP);
            Busy      <= (state_d != ST_IDLE);
            if ((state_q == ST_EXEC) && exec_last_c) begin
                Rsp_Out  <= result_c;
                Rsp_Zero <= (result_c == '0);
                Rsp_Id   <= id_q;
            end
        end
    end

endmodule
